// File: rtl/syn_weight_acc.sv
// Serial synaptic accumulator: walks the weight store once per start and
// produces the saturated sum of weights whose presynaptic input spiked.
module syn_weight_acc #(
    parameter int n_stage  = 6,
    parameter int n_inputs = 8,
    localparam int W  = n_stage + 2,
    localparam int AW = ($clog2(n_inputs) > 1) ? $clog2(n_inputs) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [n_inputs-1:0] x_in,
    output logic [AW-1:0]       w_addr,
    input  logic [W-1:0]        w_data,
    output logic [W-1:0]        sum_wx,
    output logic                done,
    output logic                busy,
    output logic                sat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST  = AW'(n_inputs - 1);
    localparam logic [W-1:0]  S_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  S_MIN = {1'b1, {(W-1){1'b0}}};

    state_t              state_q, state_d;
    logic [n_inputs-1:0] x_reg_q, x_reg_d;
    logic [W-1:0]        acc_q, acc_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic                sat_run_q, sat_run_d;
    logic [W-1:0]        sum_wx_q, sum_wx_d;
    logic                sat_q, sat_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [W:0]          sum_ext;

    always_comb begin
        state_d   = state_q;
        x_reg_d   = x_reg_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        sat_run_d = sat_run_q;
        sum_wx_d  = sum_wx_q;
        sat_d     = sat_q;
        done_d    = 1'b0;
        w_addr    = '0;
        // One guard bit: overflow shows up as the top two bits disagreeing.
        sum_ext   = {acc_q[W-1], acc_q} + {w_data[W-1], w_data};

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ACCUM;
                    x_reg_d   = x_in;
                    acc_d     = '0;
                    idx_d     = '0;
                    sat_run_d = 1'b0;
                end
            end
            ACCUM: begin
                w_addr = idx_q;
                if (x_reg_q[idx_q]) begin
                    if (sum_ext[W] != sum_ext[W-1]) begin
                        acc_d     = sum_ext[W] ? S_MIN : S_MAX;
                        sat_run_d = 1'b1;
                    end else begin
                        acc_d = sum_ext[W-1:0];
                    end
                end
                idx_d = idx_q + 1'b1;
                // Result registers load on the edge into DONE so they are valid with done.
                if (idx_q == LAST) begin
                    state_d  = DONE;
                    idx_d    = '0;
                    done_d   = 1'b1;
                    sum_wx_d = acc_d;
                    sat_d    = sat_run_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_reg_q   <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            sat_run_q <= 1'b0;
            sum_wx_q  <= '0;
            sat_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_reg_q   <= x_reg_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            sat_run_q <= sat_run_d;
            sum_wx_q  <= sum_wx_d;
            sat_q     <= sat_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign sum_wx = sum_wx_q;
    assign sat    = sat_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_syn_weight_acc.sv
// Directed bench for syn_weight_acc (W=8, 8 inputs): expected results are
// queued at stimulus time and compared when done pulses.
module tb_syn_weight_acc;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  x_in;
    logic [AW-1:0] w_addr;
    logic [W-1:0]  w_data;
    logic [W-1:0]  sum_wx;
    logic          done;
    logic          busy;
    logic          sat;

    logic signed [W-1:0] wmem [N];
    logic [W:0]          exp_q [$];
    int                  checks;
    int                  errors;
    int                  cyc;
    int                  e0;

    syn_weight_acc #(.n_stage(6), .n_inputs(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .x_in   (x_in),
        .w_addr (w_addr),
        .w_data (w_data),
        .sum_wx (sum_wx),
        .done   (done),
        .busy   (busy),
        .sat    (sat)
    );

    assign w_data = wmem[w_addr];

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: integer accumulation with per-step clamping
    function automatic logic [W:0] model(input logic [N-1:0] x);
        int   a;
        logic s;
        a = 0;
        s = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (x[i]) begin
                a = a + int'(wmem[i]);
                if (a > 127) begin
                    a = 127;
                    s = 1'b1;
                end else if (a < -128) begin
                    a = -128;
                    s = 1'b1;
                end
            end
        end
        return {s, W'(a)};
    endfunction

    // Scoreboard: every done pops one expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_done: got done=1 expected no result pending");
            end
            if (exp_q.size() != 0) begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("sum_wx", {24'd0, sum_wx}, {24'd0, e[W-1:0]});
                check("sat", {31'd0, sat}, {31'd0, e[W]});
            end
        end
    end

    task automatic set_all(input logic signed [W-1:0] v);
        for (int i = 0; i < N; i++) wmem[i] = v;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < N; i++) wmem[i] = W'(i + 1);
    endtask

    // Returns cyc at the negedge where done is seen, or -1 on timeout
    task automatic wait_done(output int at);
        at = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic accept(input logic [N-1:0] x, input bit expect_result);
        @(negedge clk);
        start = 1'b1;
        x_in  = x;
        if (expect_result) exp_q.push_back(model(x));
        @(posedge clk);
        #1;
        e0    = cyc;
        start = 1'b0;
        x_in  = N'($urandom_range(0, 255));
    endtask

    task automatic run_one(input string tag, input logic [N-1:0] x);
        int at;
        accept(x, 1'b1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_waddr0"}, {29'd0, w_addr}, 32'd0);
        wait_done(at);
        check({tag, "_latency"}, at - e0, N);
        @(negedge clk);
        check({tag, "_done_width"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int t1, t2, t3;
        checks = 0;
        errors = 0;
        start  = 1'b0;
        x_in   = '0;
        set_ramp();
        rst_n  = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum_wx}, 32'd0);
        check("rst_sat", {31'd0, sat}, 32'd0);
        check("rst_waddr", {29'd0, w_addr}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        set_ramp();
        run_one("basic", 8'hFF);

        set_all(8'sd50);
        wmem[0] = -8'sd3;
        wmem[2] = 8'sd10;
        run_one("sparse", 8'b0000_0101);

        set_all(8'sd100);
        run_one("sat_pos", 8'hFF);

        set_all(-8'sd100);
        run_one("sat_neg", 8'hFF);

        set_all(8'sd0);
        wmem[0] = 8'sd100;
        wmem[1] = 8'sd100;
        wmem[2] = -8'sd50;
        run_one("recover", 8'h07);

        set_ramp();
        run_one("zero", 8'h00);

        // start pulse mid-ACCUM with a different vector is ignored
        accept(8'hFF, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        x_in  = 8'h01;
        @(negedge clk);
        start = 1'b0;
        wait_done(t1);
        check("ignore_latency", t1 - e0, N);

        // start held high: one result every N+2 cycles
        @(negedge clk);
        set_ramp();
        start = 1'b1;
        x_in  = 8'h0F;
        for (int i = 0; i < 3; i++) exp_q.push_back(model(8'h0F));
        wait_done(t1);
        wait_done(t2);
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(t3);
        check("held_spacing1", t2 - t1, N + 2);
        check("held_spacing2", t3 - t2, N + 2);
        repeat (2) @(negedge clk);

        // reset mid-ACCUM: outputs clear at once, no result is issued
        accept(8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_sum", {24'd0, sum_wx}, 32'd0);
        check("midrst_sat", {31'd0, sat}, 32'd0);
        check("midrst_waddr", {29'd0, w_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_one("after_rst", 8'hAA);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
